// File: rtl/seq_det_pkg.sv
// seq_det_pkg
// Shared definitions for the runtime-programmable serial pattern detector:
//   - state_e         : FSM state encodings (ST_FILL, ST_DETECT)
//   - MODE_OVERLAP    : overlap mode select value (1)
//   - MODE_NONOVERLAP : non-overlap mode select value (0)
//   - lenIsValid()    : accepts a pattern length in the range 2..maxLen
package seq_det_pkg;

  typedef enum logic [1:0] {
    ST_FILL   = 2'b01,
    ST_DETECT = 2'b10
  } state_e;

  localparam logic MODE_OVERLAP    = 1'b1;
  localparam logic MODE_NONOVERLAP = 1'b0;

  // A single-bit pattern is meaningless for a sequence detector, so the
  // smallest accepted length is two.
  function automatic logic lenIsValid(input int unsigned len,
                                      input int unsigned maxLen);
    return (len >= 32'd2) && (len <= maxLen);
  endfunction

endpackage

// File: rtl/seq_history_shreg.sv
// seq_history_shreg
// Bit-history shift register with a fill counter that saturates at the
// programmed pattern length.
// Ports:
//   clk_i     : clock, rising edge
//   rst_ni    : synchronous active-low reset
//   clear_i   : clears history and fill (new configuration)
//   fillClr_i : clears the fill counter only; history keeps shifting
//   shift_i   : shift bit_i into the history this cycle
//   bit_i     : serial data bit
//   len_i     : current pattern length (fill saturation point)
//   hist_o    : history, newest bit at LSB
//   fill_o    : number of sampled bits, saturated at len_i
module seq_history_shreg
  import seq_det_pkg::*;
#(
  parameter int HIST_W = 15,
  parameter int LEN_W  = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              fillClr_i,
  input  logic              shift_i,
  input  logic              bit_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic [HIST_W-1:0] hist_o,
  output logic [LEN_W-1:0]  fill_o
);

  localparam logic [LEN_W-1:0] FILL_ONE = LEN_W'(1);

  logic [HIST_W-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]  fill_q, fill_d;

  // Fill clear wins over the increment: the bit shifted in on a
  // non-overlapping match belongs to the pattern just consumed.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clear_i) begin
      hist_d = '0;
      fill_d = '0;
    end else begin
      if (shift_i) begin
        hist_d = {hist_q[HIST_W-2:0], bit_i};
        if (fill_q < len_i) begin
          fill_d = fill_q + FILL_ONE;
        end
      end
      if (fillClr_i) begin
        fill_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

  assign hist_o = hist_q;
  assign fill_o = fill_q;

endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param
// Runtime-programmable serial bit-pattern detector with overlapping and
// non-overlapping modes, input-valid qualifier and saturating match counter.
// Optional feature macro: SEQDET_COUNT_EN (builds the match counter; when
// undefined match_count is tied to zero).
// Ports:
//   clk_pulse   : clock, rising edge
//   clear_n     : synchronous active-low reset
//   inp_valid   : qualifies inp_1
//   inp_1       : serial data bit
//   cfg_we      : load pattern/length/mode
//   cfg_pattern : new pattern, bit [len-1] arrives first, bit 0 last
//   cfg_len     : new pattern length
//   cfg_overlap : 1 overlapping, 0 non-overlapping
//   match       : one-cycle pulse on detection
//   match_count : saturating match count
//   cfg_err     : one-cycle pulse on a rejected configuration
//   state       : present FSM state for debug LEDs
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                 MAX_LEN     = 16,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = 16'b0000_0000_0001_1011,
  parameter int                 DEF_LEN     = 5,
  parameter int                 CNT_W       = 8
) (
  input  logic                         clk_pulse,
  input  logic                         clear_n,
  input  logic                         inp_valid,
  input  logic                         inp_1,
  input  logic                         cfg_we,
  input  logic [MAX_LEN-1:0]           cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
  input  logic                         cfg_overlap,
  output logic                         match,
  output logic [CNT_W-1:0]             match_count,
  output logic                         cfg_err,
  output logic [1:0]                   state
);

  localparam int LEN_W = $clog2(MAX_LEN+1);
  // The oldest of MAX_LEN history bits can never take part in a compare,
  // since the live bit always fills the LSB of the candidate window.
  localparam int HIST_W = MAX_LEN - 1;
  localparam logic [LEN_W-1:0] DEF_LEN_V = LEN_W'(DEF_LEN);
  localparam logic [LEN_W:0]   FILL_ONE  = (LEN_W+1)'(1);

  state_e               state_q, state_d;
  logic [MAX_LEN-1:0]   pattern_q;
  logic [LEN_W-1:0]     len_q;
  logic                 overlap_q;
  logic                 match_q, cfgErr_q;

  logic [HIST_W-1:0]    hist;
  logic [LEN_W-1:0]     fill;
  logic [MAX_LEN-1:0]   lenMask, cand;
  logic [LEN_W:0]       fillPlus;
  logic                 cfgValid, cfgReject, sampleBit, lastBit, hit;
  logic                 illegalState, fillClr;

  // Config handling: a valid write pre-empts the data bit of the same cycle,
  // an invalid one is only flagged and leaves detection alone.
  always_comb begin
    cfgValid  = cfg_we && lenIsValid(32'(cfg_len), MAX_LEN);
    cfgReject = cfg_we && !cfgValid;
    sampleBit = inp_valid && !cfgValid;
  end

  // Compare window: the stored history plus the bit arriving now, so a match
  // is registered on the same edge that samples the final bit.
  always_comb begin
    lenMask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      lenMask[i] = (i < int'(len_q));
    end
    cand     = {hist, inp_1};
    fillPlus = {1'b0, fill} + FILL_ONE;
    lastBit  = (fillPlus >= {1'b0, len_q});
    hit      = sampleBit && lastBit &&
               ((cand & lenMask) == (pattern_q & lenMask));
  end

  // Next-state logic; in non-overlapping mode every match restarts the fill,
  // even the first one seen while still in FILL.
  always_comb begin
    state_d      = state_q;
    illegalState = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (sampleBit && lastBit) begin
          state_d = ST_DETECT;
        end
      end
      ST_DETECT: begin
        state_d = ST_DETECT;
      end
      default: begin
        state_d      = ST_FILL;
        illegalState = 1'b1;
      end
    endcase
    if (hit && (overlap_q == MODE_NONOVERLAP)) begin
      state_d = ST_FILL;
    end
    if (cfgValid) begin
      state_d = ST_FILL;
    end
    fillClr = illegalState || (hit && (overlap_q == MODE_NONOVERLAP));
  end

  // Control and configuration registers.
  always_ff @(posedge clk_pulse) begin
    if (!clear_n) begin
      state_q   <= ST_FILL;
      pattern_q <= DEF_PATTERN;
      len_q     <= DEF_LEN_V;
      overlap_q <= MODE_OVERLAP;
      match_q   <= 1'b0;
      cfgErr_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      match_q  <= hit;
      cfgErr_q <= cfgReject;
      if (cfgValid) begin
        pattern_q <= cfg_pattern;
        len_q     <= cfg_len;
        overlap_q <= cfg_overlap;
      end
    end
  end

  seq_history_shreg #(
    .HIST_W (HIST_W),
    .LEN_W  (LEN_W)
  ) uHistory (
    .clk_i     (clk_pulse),
    .rst_ni    (clear_n),
    .clear_i   (cfgValid),
    .fillClr_i (fillClr),
    .shift_i   (sampleBit),
    .bit_i     (inp_1),
    .len_i     (len_q),
    .hist_o    (hist),
    .fill_o    (fill)
  );

`ifdef SEQDET_COUNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  logic [CNT_W-1:0] count_q, count_d;

  // Counter steps on the same edge that raises match and sticks at all-ones.
  always_comb begin
    count_d = count_q;
    if (hit && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk_pulse) begin
    if (!clear_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign match_count = count_q;
`else
  assign match_count = '0;
`endif

  assign match   = match_q;
  assign cfg_err = cfgErr_q;
  assign state   = state_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param
// Directed bench for seq_detector_param (MAX_LEN=16, CNT_W=2). Expected match
// values are queued as each step is driven and popped when the edge that
// produces the output has passed. Count expectations follow SEQDET_COUNT_EN.
module tb_seq_detector_param;

  localparam int MAX_LEN = 16;
  localparam int LEN_W   = 5;
  localparam int CNT_W   = 2;
`ifdef SEQDET_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic               clk_pulse = 1'b0;
  logic               clear_n;
  logic               inp_valid;
  logic               inp_1;
  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               match;
  logic [CNT_W-1:0]   match_count;
  logic               cfg_err;
  logic [1:0]         state;

  int checks = 0;
  int errors = 0;
  logic expQ[$];

  seq_detector_param #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk_pulse   (clk_pulse),
    .clear_n     (clear_n),
    .inp_valid   (inp_valid),
    .inp_1       (inp_1),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .match       (match),
    .match_count (match_count),
    .cfg_err     (cfg_err),
    .state       (state)
  );

  always #5 clk_pulse = ~clk_pulse;

  // Single comparison point: counts every check and reports failures.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of stimulus (inputs change at the falling edge), queue
  // the expected match, then compare just after the rising edge.
  task automatic applyStimulus(input logic v, input logic b, input logic we,
                               input logic [MAX_LEN-1:0] pat,
                               input logic [LEN_W-1:0] len, input logic ov,
                               input logic expMatch, input logic expErr,
                               input string tag);
    logic exp;
    inp_valid   = v;
    inp_1       = b;
    cfg_we      = we;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ov;
    expQ.push_back(expMatch);
    @(posedge clk_pulse);
    #1;
    exp = expQ.pop_front();
    checkOutput({tag, ".match"}, 32'(match), 32'(exp));
    checkOutput({tag, ".cfg_err"}, 32'(cfg_err), 32'(expErr));
    @(negedge clk_pulse);
    cfg_we    = 1'b0;
    inp_valid = 1'b0;
  endtask

  task automatic sendBit(input logic v, input logic b, input logic expMatch,
                         input string tag);
    applyStimulus(v, b, 1'b0, '0, '0, 1'b0, expMatch, 1'b0, tag);
  endtask

  task automatic resetDut(input string tag);
    clear_n   = 1'b0;
    inp_valid = 1'b0;
    cfg_we    = 1'b0;
    @(posedge clk_pulse);
    #1;
    checkOutput({tag, ".rst.match"}, 32'(match), 32'd0);
    checkOutput({tag, ".rst.count"}, 32'(match_count), 32'd0);
    checkOutput({tag, ".rst.cfg_err"}, 32'(cfg_err), 32'd0);
    checkOutput({tag, ".rst.state"}, 32'(state), 32'd1);
    @(negedge clk_pulse);
    clear_n = 1'b1;
  endtask

  task automatic checkCount(input int n, input string tag);
    checkOutput({tag, ".count"}, 32'(match_count), CNT_ON ? 32'(n) : 32'd0);
  endtask

  initial begin
    logic [7:0] s1;
    logic [7:0] e1;
    clear_n     = 1'b0;
    inp_valid   = 1'b0;
    inp_1       = 1'b0;
    cfg_we      = 1'b0;
    cfg_pattern = '0;
    cfg_len     = '0;
    cfg_overlap = 1'b0;
    @(negedge clk_pulse);

    // Defaults, overlapping: 11011011 -> matches after bits 5 and 8
    resetDut("t1");
    s1 = 8'b11011011;
    e1 = 8'b00001001;
    for (int i = 7; i >= 0; i--) sendBit(1'b1, s1[i], e1[i], "t1");
    sendBit(1'b0, 1'b1, 1'b0, "t1.idle");
    checkCount(2, "t1");
    checkOutput("t1.state", 32'(state), 32'd2);

    // Non-overlapping 11011: only the match after bit 5
    resetDut("t2");
    applyStimulus(1'b0, 1'b0, 1'b1, 16'b11011, 5'd5, 1'b0, 1'b0, 1'b0, "t2.cfg");
    e1 = 8'b00001000;
    for (int i = 7; i >= 0; i--) sendBit(1'b1, s1[i], e1[i], "t2");
    checkCount(1, "t2");
    checkOutput("t2.state", 32'(state), 32'd1);

    // len 4, 1010 x4, non-overlapping: 4 matches, counter saturates at 3
    resetDut("t3");
    applyStimulus(1'b0, 1'b0, 1'b1, 16'b1010, 5'd4, 1'b0, 1'b0, 1'b0, "t3.cfg");
    for (int r = 0; r < 4; r++) begin
      sendBit(1'b1, 1'b1, 1'b0, "t3");
      sendBit(1'b1, 1'b0, 1'b0, "t3");
      sendBit(1'b1, 1'b1, 1'b0, "t3");
      sendBit(1'b1, 1'b0, 1'b1, "t3");
    end
    checkCount(3, "t3");

    // Valid gaps carry junk data that must not be sampled
    resetDut("t4");
    sendBit(1'b1, 1'b1, 1'b0, "t4");
    sendBit(1'b0, 1'b0, 1'b0, "t4.gap");
    sendBit(1'b1, 1'b1, 1'b0, "t4");
    sendBit(1'b0, 1'b1, 1'b0, "t4.gap");
    sendBit(1'b0, 1'b0, 1'b0, "t4.gap");
    sendBit(1'b1, 1'b0, 1'b0, "t4");
    sendBit(1'b1, 1'b1, 1'b0, "t4");
    sendBit(1'b0, 1'b0, 1'b0, "t4.gap");
    sendBit(1'b1, 1'b1, 1'b1, "t4");
    sendBit(1'b0, 1'b1, 1'b0, "t4.after");
    checkCount(1, "t4");

    // Rejected lengths 1 and 17 mid-stream; detection still fires
    resetDut("t5");
    sendBit(1'b1, 1'b1, 1'b0, "t5");
    sendBit(1'b1, 1'b1, 1'b0, "t5");
    sendBit(1'b1, 1'b0, 1'b0, "t5");
    applyStimulus(1'b0, 1'b0, 1'b1, 16'hFFFF, 5'd1, 1'b0, 1'b0, 1'b1, "t5.len1");
    sendBit(1'b1, 1'b1, 1'b0, "t5");
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000, 5'd17, 1'b0, 1'b0, 1'b1, "t5.len17");
    sendBit(1'b1, 1'b1, 1'b1, "t5");
    checkCount(1, "t5");

    // Reset after 1101 discards history; the final 1 must not match
    resetDut("t6a");
    sendBit(1'b1, 1'b1, 1'b0, "t6");
    sendBit(1'b1, 1'b1, 1'b0, "t6");
    sendBit(1'b1, 1'b0, 1'b0, "t6");
    sendBit(1'b1, 1'b1, 1'b0, "t6");
    resetDut("t6b");
    sendBit(1'b1, 1'b1, 1'b0, "t6");
    checkOutput("t6.state", 32'(state), 32'd1);
    checkCount(0, "t6");

    // Valid config with a valid bit: bit discarded, history cleared
    resetDut("t7");
    sendBit(1'b1, 1'b1, 1'b0, "t7");
    sendBit(1'b1, 1'b1, 1'b0, "t7");
    sendBit(1'b1, 1'b0, 1'b0, "t7");
    sendBit(1'b1, 1'b1, 1'b0, "t7");
    applyStimulus(1'b1, 1'b1, 1'b1, 16'b11011, 5'd5, 1'b1, 1'b0, 1'b0, "t7.cfg");
    sendBit(1'b1, 1'b1, 1'b0, "t7");
    sendBit(1'b1, 1'b1, 1'b0, "t7");
    sendBit(1'b1, 1'b0, 1'b0, "t7");
    sendBit(1'b1, 1'b1, 1'b0, "t7");
    sendBit(1'b1, 1'b1, 1'b1, "t7");
    checkCount(1, "t7");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
